ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_pkg.sv | 37 +++
 rtl/ssd_hex_decoder.sv | 32 +++
 rtl/ssd_scan_driver.sv | 102 ++++++++++
 tb/tb_ssd_scan_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns (active-low {g,f,e,d,c,b,a}),
// blank/off codes, digit count and the leading-zero helper used when SSD_SCAN_LZ_BLANK_EN is defined.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Index of the most significant nonzero nibble; 0 for an all-zero value so digit 0 always shows.
  function automatic logic [2:0] lz_top_digit(input logic [31:0] v);
    logic [2:0] top;
    top = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) top = 3'(k);
    end
    return top;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with frame-synchronous shadow registers.
// Optional leading-zero blanking is enabled by defining SSD_SCAN_LZ_BLANK_EN.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        ssd_scan_port_clk,
  input  logic        ssd_scan_port_rst,
  input  logic        ssd_scan_port_en,
  input  logic [31:0] ssd_scan_port_value,
  input  logic [7:0]  ssd_scan_port_dig_en,
  input  logic [7:0]  ssd_scan_port_dp,
  output logic [6:0]  ssd_scan_port_ssd,
  output logic        ssd_scan_port_odp,
  output logic [7:0]  ssd_scan_port_an,
  output logic        ssd_scan_port_frame
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      val_q, val_d;
  logic [7:0]       den_q, den_d;
  logic [7:0]       dp_q, dp_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       ssd_q, ssd_d;
  logic             odp_q, odp_d;
  logic             frame_q, frame_d;
  logic             tick, load, shown;
  logic [3:0]       nib;
  logic [6:0]       seg;

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    den_d   = den_q;
    dp_d    = dp_q;
    tick    = ssd_scan_port_en && (cnt_q == CNT_MAX);
    load    = tick && (idx_q == 3'd7);
    frame_d = load;
    if (ssd_scan_port_en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (tick) idx_d = idx_q + 3'd1;
    if (load) begin
      val_d = ssd_scan_port_value;
      den_d = ssd_scan_port_dig_en;
      dp_d  = ssd_scan_port_dp;
    end
  end

  // Outputs are computed from next-state so the registered display tracks the new slot immediately.
  assign nib = val_d[{idx_d, 2'b00} +: 4];

  ssd_hex_decoder u_dec (
    .hex_i (nib),
    .seg_o (seg)
  );

  always_comb begin
`ifdef SSD_SCAN_LZ_BLANK_EN
    shown = ssd_scan_port_en && den_d[idx_d] && (idx_d <= lz_top_digit(val_d));
`else
    shown = ssd_scan_port_en && den_d[idx_d];
`endif
    an_d  = shown ? ~(8'd1 << idx_d) : AN_OFF;
    ssd_d = shown ? seg : SEG_BLANK;
    odp_d = shown ? ~dp_d[idx_d] : 1'b1;
  end

  always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst) begin
    if (!ssd_scan_port_rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      val_q   <= 32'd0;
      den_q   <= 8'd0;
      dp_q    <= 8'd0;
      an_q    <= AN_OFF;
      ssd_q   <= SEG_BLANK;
      odp_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      den_q   <= den_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      ssd_q   <= ssd_d;
      odp_q   <= odp_d;
      frame_q <= frame_d;
    end
  end

  assign ssd_scan_port_ssd   = ssd_q;
  assign ssd_scan_port_odp   = odp_q;
  assign ssd_scan_port_an    = an_q;
  assign ssd_scan_port_frame = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed scan/frame/enable/reset steps plus randomized inputs,
// all checked against a slot-count reference model of the display.
module tb_ssd_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] value = 32'd0;
  logic [7:0]  dig_en = 8'd0;
  logic [7:0]  dp = 8'd0;
  logic [6:0]  ssd, ssd1;
  logic        odp, odp1;
  logic [7:0]  an, an1;
  logic        frame, frame1;

  int total = 0;
  int bad = 0;
  int frame_seen = 0;
  int shown_cnt = 0;
  logic [14:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  ssd_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .ssd_scan_port_clk    (clk),
    .ssd_scan_port_rst    (rst_n),
    .ssd_scan_port_en     (en),
    .ssd_scan_port_value  (value),
    .ssd_scan_port_dig_en (dig_en),
    .ssd_scan_port_dp     (dp),
    .ssd_scan_port_ssd    (ssd),
    .ssd_scan_port_odp    (odp),
    .ssd_scan_port_an     (an),
    .ssd_scan_port_frame  (frame)
  );

  ssd_scan_driver #(.REFRESH_DIV(1)) dut1 (
    .ssd_scan_port_clk    (clk),
    .ssd_scan_port_rst    (rst_n),
    .ssd_scan_port_en     (en),
    .ssd_scan_port_value  (value),
    .ssd_scan_port_dig_en (dig_en),
    .ssd_scan_port_dp     (dp),
    .ssd_scan_port_ssd    (ssd1),
    .ssd_scan_port_odp    (odp1),
    .ssd_scan_port_an     (an1),
    .ssd_scan_port_frame  (frame1)
  );

  // Reference model: counts enabled cycles within a frame; the slot shown is that count / DIV.
  int          m_cnt;
  logic [31:0] m_val;
  logic [7:0]  m_den, m_dp;
  logic        m_en, m_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_val = 0; m_den = 0; m_dp = 0; m_en = 0; m_frame = 0;
    end else begin
      m_en = en;
      m_frame = 0;
      if (en) begin
        m_cnt = (m_cnt + 1) % FRAME;
        if (m_cnt == 0) begin
          m_frame = 1; m_val = value; m_den = dig_en; m_dp = dp;
        end
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[h];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_model();
    int idx;
    logic shown;
    logic [7:0] e_an;
    logic [6:0] e_ssd;
    logic e_odp;
    idx = m_cnt / DIV;
    shown = m_en && m_den[idx];
`ifdef SSD_SCAN_LZ_BLANK_EN
    begin
      int top;
      top = 0;
      for (int k = 0; k < 8; k++) if (m_val[4*k +: 4] != 4'h0) top = k;
      if (idx > top) shown = 1'b0;
    end
`endif
    e_an  = 8'hFF;
    if (shown) e_an[idx] = 1'b0;
    e_ssd = shown ? seg_of(m_val[4*idx +: 4]) : 7'h7F;
    e_odp = shown ? ~m_dp[idx] : 1'b1;
    check("model_an", an, e_an);
    check("model_ssd", ssd, e_ssd);
    check("model_odp", odp, e_odp);
    check("model_frame", frame, m_frame);
  endtask

  // driver: advance n clocks, checking every cycle on the falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame === 1'b1) frame_seen++;
      if (an !== 8'hFF) shown_cnt++;
      chk_model();
    end
  endtask

  initial begin
    logic [7:0] an_v;
    logic [6:0] ssd_list [8];
    logic [14:0] e;

    // reset held with live inputs: display stays blank
    value = 32'h12345678; dig_en = 8'hFF; dp = 8'h00; en = 1'b1;
    step(3);
    check("reset_an", an, 8'hFF);
    check("reset_ssd", ssd, 7'h7F);
    check("reset_odp", odp, 1'b1);
    check("reset_frame", frame, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    frame_seen = 0;
    for (int j = 1; j <= 31; j++) begin
      step(1);
      an_v = 8'hFF;
      if (j >= 8) an_v[j % 8] = 1'b0;
      check("div1_an", an1, an_v);
      check("div1_frame", frame1, (j % 8) == 0);
    end
    check("no_early_frame", frame_seen, 0);

    // full scan of the first loaded frame
    ssd_list = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 8; k++) begin
      an_v = 8'hFF;
      an_v[k] = 1'b0;
      for (int r = 0; r < DIV; r++) exp_q.push_back({an_v, ssd_list[k]});
    end
    for (int j = 0; j < FRAME; j++) begin
      step(1);
      if (j == 0) begin
        check("first_frame_pulse", frame, 1'b1);
        check("first_digit_ssd", ssd, 7'h00);
        check("first_digit_an", an, 8'hFE);
      end
      e = exp_q.pop_front();
      check("scan_walk", {an, ssd}, e);
    end

    // mid-frame value change must not tear
    step(3);
    value = 32'hFFFFFFFF;
    step(29);
    check("old_digit7_kept", ssd, 7'h79);
    step(1);
    check("new_frame_pulse", frame, 1'b1);
    check("new_value_ssd", ssd, 7'h0E);

    // digit enable and decimal-point masks
    dig_en = 8'h0F; dp = 8'h01;
    step(32);
    check("dp_digit0", odp, 1'b0);
    check("dp_digit0_an", an, 8'hFE);
    step(4);
    check("dp_digit1_off", odp, 1'b1);
    step(12);
    check("digit4_off", an, 8'hFF);

    // enable low across the frame boundary
    step(15);
    en = 1'b0;
    frame_seen = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      check("en_low_blank", an, 8'hFF);
    end
    check("en_low_no_frame", frame_seen, 0);
    en = 1'b1;
    step(1);
    check("resume_frame", frame, 1'b1);
    check("resume_an", an, 8'hFE);

    // randomized inputs
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) value = $urandom;
      if ($urandom_range(0, 7) == 0) dig_en = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      step(1);
    end

    // asynchronous reset mid-frame
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", an, 8'hFF);
    check("async_rst_ssd", ssd, 7'h7F);
    check("async_rst_odp", odp, 1'b1);
    check("async_rst_frame", frame, 1'b0);
    value = 32'h00000A05; dig_en = 8'hFF; dp = 8'h00; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    frame_seen = 0;
    step(31);
    check("post_rst_no_frame", frame_seen, 0);
    step(1);
    check("post_rst_frame", frame, 1'b1);

    // leading-zero blanking (or its absence in the default build)
    shown_cnt = 0;
    step(32);
`ifdef SSD_SCAN_LZ_BLANK_EN
    check("lz_a05_shown", shown_cnt, 3 * DIV);
`else
    check("lz_a05_shown", shown_cnt, 8 * DIV);
`endif
    value = 32'h00000000;
    step(32);
    shown_cnt = 0;
    step(32);
`ifdef SSD_SCAN_LZ_BLANK_EN
    check("lz_zero_shown", shown_cnt, DIV);
`else
    check("lz_zero_shown", shown_cnt, 8 * DIV);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
